mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one 64-bit OBI host port between the fetch-stage instruction requester and the memory-stage data requester. Used on single-port memory configurations.
- Sits between the two obi_host_driver instances and the external bus.
- Arbitrates requests, locks the address phase until grant, tracks outstanding transactions in a small in-order ID FIFO, and steers rvalid/rdata back to the issuing requester.

Parameters:
- MAX_OUTST, 2, maximum outstanding (granted, not yet rvalid) transactions; power of 2, range 1..4.
- STARVE_LIMIT, 4, consecutive cycles imem may be denied while requesting before it is forced to win.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- imem_req_i  in  1  instruction request
- imem_addr_i  in  64  instruction address; read-only, byte-aligned to 4
- imem_gnt_o  out  1  instruction grant
- imem_rvalid_o  out  1  instruction response valid
- imem_rdata_o  out  32  instruction word
- dmem_req_i  in  1  data request
- dmem_addr_i  in  64  data address
- dmem_we_i  in  1  data write enable
- dmem_be_i  in  8  data byte enables
- dmem_wdata_i  in  64  data write data
- dmem_gnt_o  out  1  data grant
- dmem_rvalid_o  out  1  data response valid
- dmem_rdata_o  out  64  data read data
- bus_req_o  out  1  shared bus request
- bus_gnt_i  in  1  shared bus grant
- bus_addr_o  out  64  shared bus address
- bus_we_o  out  1  shared bus write enable
- bus_be_o  out  8  shared bus byte enables
- bus_wdata_o  out  64  shared bus write data
- bus_rvalid_i  in  1  shared bus response valid
- bus_rdata_i  in  64  shared bus read data
- outst_cnt_o  out  3  outstanding transaction count
- err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Reset (rst_i sampled high at posedge):
  - FSM to IDLE; FIFO emptied; starve counter 0; err_o 0; outst_cnt_o 0.
  - All outputs are combinational from reset state, so bus_req_o/gnt/rvalid outputs are 0 while no requests are present.
  - Reset mid-transaction drops all tracking. A later bus_rvalid_i for a pre-reset transaction sets err_o and is not forwarded.
- FSM states:
  - IDLE: no pending address phase. Winner selected combinationally.
  - LOCK_I / LOCK_D: bus_req_o was asserted without bus_gnt_i. The owner is held; address-phase outputs come from the owner only; the other requester is ignored.
  - LOCK_x returns to IDLE in the cycle bus_gnt_i=1.
  - If the owner drops req while locked (OBI violation), go to IDLE with no grant.
- Arbitration in IDLE:
  - dmem wins if dmem_req_i=1, unless starve counter == STARVE_LIMIT and imem_req_i=1, in which case imem wins.
  - Starve counter increments (saturating) each cycle imem_req_i=1 and imem is not granted. It clears on imem grant or when imem_req_i=0.
- Capacity gating:
  - bus_req_o = owner_req & (count < MAX_OUTST).
  - When full, no request is issued and the FSM stays in IDLE. A same-cycle pop does not free the slot until the next cycle.
- Bus pass-through:
  - Address-phase bus outputs mux from the winner/owner. imem path: we=0, be=8'hFF, wdata=0.
  - x_gnt_o = bus_gnt_i & bus_req_o & (owner==x). Zero-latency pass-through.
- Tracking FIFO:
  - On every handshake (bus_req_o & bus_gnt_i), push entry {src, addr[2]}, where src 1 = dmem.
  - On bus_rvalid_i, pop the head. Route to the head's src in the same cycle (combinational).
  - imem_rdata_o = head.addr2 ? bus_rdata_i[63:32] : bus_rdata_i[31:0]. dmem_rdata_o = bus_rdata_i.
  - Push and pop in the same cycle: count unchanged; order preserved.
  - Pointers wrap mod MAX_OUTST.
  - rvalid arriving in the same cycle as the grant of the transaction being pushed to an empty FIFO is illegal for OBI (rvalid ≥1 cycle after gnt) and is treated as spurious.
- Spurious response: bus_rvalid_i with count==0 sets err_o (sticky until reset); no rvalid is forwarded.
- outst_cnt_o reflects the registered count.

Test Plan:
- Both requesters assert at cycle 0; dmem addr 0x100, imem addr 0x8000_0000; gnt_i=1 always, rvalid 1 cycle later -> dmem granted at cycles 0..3; imem forced grant at cycle 4 (STARVE_LIMIT=4); responses routed to dmem x4 then imem, in order.
- imem req addr 0x8000_0004, gnt_i held 0 for 3 cycles while dmem_req_i rises at cycle 1 -> bus_addr_o stays 0x8000_0004 throughout; imem_gnt_o at cycle 3; dmem granted at cycle 4.
- Back-to-back dmem reads, gnt_i=1, rvalid withheld -> two grants, then bus_req_o=0 with outst_cnt_o=2; rvalid at cycle 5 -> bus_req_o resumes at cycle 6.
- imem read addr 0x8000_0004, bus_rdata_i=0x1111_2222_3333_4444 -> imem_rdata_o=0x1111_2222. Same with addr 0x8000_0000 -> 0x3333_4444.
- bus_rvalid_i pulse with no outstanding transaction -> err_o=1 next cycle and stays 1 until rst_i; no rvalid is forwarded.
- Reset asserted with 2 outstanding, then rvalid -> outst_cnt_o=0 after reset; the late rvalid sets err_o; no forwarding.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit OBI host port between the instruction and data requesters.
// Holds the address phase until grant and steers responses through an in-order ID FIFO.
module mem_port_arbiter #(
   parameter int MAX_OUTST    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        imem_req_i,
   input  logic [63:0] imem_addr_i,
   output logic        imem_gnt_o,
   output logic        imem_rvalid_o,
   output logic [31:0] imem_rdata_o,
   input  logic        dmem_req_i,
   input  logic [63:0] dmem_addr_i,
   input  logic        dmem_we_i,
   input  logic [7:0]  dmem_be_i,
   input  logic [63:0] dmem_wdata_i,
   output logic        dmem_gnt_o,
   output logic        dmem_rvalid_o,
   output logic [63:0] dmem_rdata_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   output logic [63:0] bus_addr_o,
   output logic        bus_we_o,
   output logic [7:0]  bus_be_o,
   output logic [63:0] bus_wdata_o,
   input  logic        bus_rvalid_i,
   input  logic [63:0] bus_rdata_i,
   output logic [2:0]  outst_cnt_o,
   output logic        err_o
);

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2} state_t;

   state_t               state_r, state_s;
   logic [SW-1:0]        starve_r, starve_s;
   logic [2:0]           count_r;
   logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
   logic [MAX_OUTST-1:0] src_q_r, addr2_q_r;
   logic                 err_r;
   logic                 own_d_s, own_req_s, req_s, push_s, pop_s, spur_s;
   logic                 head_src_s, head_a2_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // Owner selection, capacity gating and lock FSM next state
   always_comb begin
      own_d_s   = 1'b0;
      own_req_s = 1'b0;
      state_s   = state_r;
      case (state_r)
         IDLE: begin
            if (dmem_req_i && !(imem_req_i && (starve_r == SW'(STARVE_LIMIT)))) begin
               own_d_s = 1'b1;
            end else begin
               own_d_s = 1'b0;
            end
            own_req_s = imem_req_i | dmem_req_i;
         end
         LOCK_I: own_req_s = imem_req_i;
         LOCK_D: begin
            own_d_s   = 1'b1;
            own_req_s = dmem_req_i;
         end
         default: own_req_s = 1'b0;
      endcase
      req_s = own_req_s && (count_r < 3'(MAX_OUTST));
      case (state_r)
         IDLE: begin
            if (req_s && !bus_gnt_i) begin
               state_s = own_d_s ? LOCK_D : LOCK_I;
            end else begin
               state_s = IDLE;
            end
         end
         LOCK_I, LOCK_D: begin
            // An owner withdrawing its request mid-lock releases the lock without a grant
            if (!own_req_s || bus_gnt_i) begin
               state_s = IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Starvation counter for the instruction requester
   always_comb begin
      starve_s = starve_r;
      if (imem_req_i && !imem_gnt_o) begin
         starve_s = (starve_r == SW'(STARVE_LIMIT)) ? starve_r : starve_r + SW'(1);
      end else begin
         starve_s = {SW{1'b0}};
      end
   end

   assign bus_req_o   = req_s;
   assign bus_addr_o  = own_d_s ? dmem_addr_i  : imem_addr_i;
   assign bus_we_o    = own_d_s ? dmem_we_i    : 1'b0;
   assign bus_be_o    = own_d_s ? dmem_be_i    : 8'hFF;
   assign bus_wdata_o = own_d_s ? dmem_wdata_i : 64'h0;
   assign imem_gnt_o  = bus_gnt_i & req_s & ~own_d_s;
   assign dmem_gnt_o  = bus_gnt_i & req_s & own_d_s;

   assign push_s     = req_s & bus_gnt_i;
   assign pop_s      = bus_rvalid_i & (count_r != 3'd0);
   assign spur_s     = bus_rvalid_i & (count_r == 3'd0);
   assign head_src_s = src_q_r[rd_ptr_r];
   assign head_a2_s  = addr2_q_r[rd_ptr_r];

   assign imem_rvalid_o = pop_s & ~head_src_s;
   assign dmem_rvalid_o = pop_s & head_src_s;
   assign imem_rdata_o  = head_a2_s ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
   assign dmem_rdata_o  = bus_rdata_i;
   assign outst_cnt_o   = count_r;
   assign err_o         = err_r;

   // State, starvation, tracking FIFO and sticky error registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         starve_r  <= {SW{1'b0}};
         count_r   <= 3'd0;
         wr_ptr_r  <= {PW{1'b0}};
         rd_ptr_r  <= {PW{1'b0}};
         src_q_r   <= {MAX_OUTST{1'b0}};
         addr2_q_r <= {MAX_OUTST{1'b0}};
         err_r     <= 1'b0;
      end else begin
         state_r  <= state_s;
         starve_r <= starve_s;
         if (push_s) begin
            src_q_r[wr_ptr_r]   <= own_d_s;
            addr2_q_r[wr_ptr_r] <= bus_addr_o[2];
            wr_ptr_r            <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
         if (spur_s) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued at grant time
// and compared when the arbiter forwards rvalid.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_i, imem_gnt_o, imem_rvalid_o;
   logic [63:0] imem_addr_i;
   logic [31:0] imem_rdata_o;
   logic        dmem_req_i, dmem_we_i, dmem_gnt_o, dmem_rvalid_o;
   logic [63:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
   logic [7:0]  dmem_be_i, bus_be_o;
   logic        bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i, err_o;
   logic [63:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic [2:0]  outst_cnt_o;

   typedef struct packed {
      logic        src;
      logic [63:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
      .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
      .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_we_i(dmem_we_i),
      .dmem_be_i(dmem_be_i), .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o),
      .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
      .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
      .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
      .outst_cnt_o(outst_cnt_o), .err_o(err_o)
   );

   function automatic logic [63:0] rd_pat(input int t, input int c);
      return {32'hA000_0000 + 32'(t), 32'hB000_0000 + 32'(c)};
   endfunction

   // Response monitor: every forwarded rvalid must match the scoreboard head
   always @(negedge clk_i) begin : monitor
      exp_t e;
      #2;
      if (imem_rvalid_o || dmem_rvalid_o) begin
         checks++;
         if (imem_rvalid_o && dmem_rvalid_o) begin
            errors++;
            $display("FAIL resp_both actual=both_rvalid required=one_rvalid");
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected actual=imem:%b dmem:%b required=none", imem_rvalid_o, dmem_rvalid_o);
         end else begin
            e = sb_q.pop_front();
            if (e.src !== dmem_rvalid_o) begin
               errors++;
               $display("FAIL resp_route actual_dmem=%b required_dmem=%b", dmem_rvalid_o, e.src);
            end else if (imem_rvalid_o && (imem_rdata_o !== e.data[31:0])) begin
               errors++;
               $display("FAIL resp_imem_data actual=%h required=%h", imem_rdata_o, e.data[31:0]);
            end else if (dmem_rvalid_o && (dmem_rdata_o !== e.data)) begin
               errors++;
               $display("FAIL resp_dmem_data actual=%h required=%h", dmem_rdata_o, e.data);
            end
         end
      end
   end

   task automatic idle_in();
      imem_req_i = 1'b0; imem_addr_i = 64'h0;
      dmem_req_i = 1'b0; dmem_addr_i = 64'h0; dmem_we_i = 1'b0;
      dmem_be_i = 8'h00; dmem_wdata_i = 64'h0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 64'h0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      idle_in();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic end_test(input string name);
      @(negedge clk_i);
      idle_in();
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending actual=%0d required=0", name, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset();
      idle_in();
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checks++;
      if ({outst_cnt_o, err_o, bus_req_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o} !== 9'b0) begin
         errors++;
         $display("FAIL reset_state actual=%b required=%b",
                  {outst_cnt_o, err_o, bus_req_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o}, 9'b0);
      end
   endtask

   task automatic test_starvation();
      logic        exp_d, exp_i;
      logic [63:0] d;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_i);
         imem_req_i = (c <= 4); imem_addr_i = 64'h8000_0000;
         dmem_req_i = (c <= 4); dmem_addr_i = 64'h100; dmem_be_i = 8'hFF;
         bus_gnt_i = 1'b1; bus_rvalid_i = (c >= 1 && c <= 5); bus_rdata_i = rd_pat(1, c);
         #1;
         exp_d = (c < 4);
         exp_i = (c == 4);
         checks++;
         if ({bus_req_o, dmem_gnt_o, imem_gnt_o} !== {(c <= 4), exp_d, exp_i}) begin
            errors++;
            $display("FAIL starve_gnt c=%0d actual=%b required=%b", c, {bus_req_o, dmem_gnt_o, imem_gnt_o}, {(c <= 4), exp_d, exp_i});
         end
         if (c <= 4) begin
            checks++;
            if (bus_addr_o !== (exp_i ? 64'h8000_0000 : 64'h100)) begin
               errors++;
               $display("FAIL starve_addr c=%0d actual=%h required=%h", c, bus_addr_o, exp_i ? 64'h8000_0000 : 64'h100);
            end
            d = rd_pat(1, c + 1);
            sb_q.push_back({exp_d, exp_d ? d : {32'h0, d[31:0]}});
         end
         checks++;
         if (outst_cnt_o !== ((c == 0 || c == 6) ? 3'd0 : 3'd1)) begin
            errors++;
            $display("FAIL starve_outst c=%0d actual=%0d required=%0d", c, outst_cnt_o, (c == 0 || c == 6) ? 0 : 1);
         end
      end
      end_test("starve");
   endtask

   task automatic test_lock();
      logic exp_i, exp_d;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_i);
         imem_req_i = (c <= 3); imem_addr_i = 64'h8000_0004;
         dmem_req_i = (c >= 1 && c <= 4); dmem_addr_i = 64'h200; dmem_we_i = 1'b1;
         dmem_be_i = 8'h0F; dmem_wdata_i = 64'hDEAD_BEEF;
         bus_gnt_i = (c >= 3); bus_rvalid_i = (c == 5 || c == 6);
         bus_rdata_i = (c == 5) ? 64'h1111_2222_3333_4444 : rd_pat(2, c);
         #1;
         exp_i = (c == 3);
         exp_d = (c == 4);
         checks++;
         if ({bus_req_o, imem_gnt_o, dmem_gnt_o} !== {(c <= 4), exp_i, exp_d}) begin
            errors++;
            $display("FAIL lock_gnt c=%0d actual=%b required=%b", c, {bus_req_o, imem_gnt_o, dmem_gnt_o}, {(c <= 4), exp_i, exp_d});
         end
         if (c <= 3) begin
            checks++;
            if ({bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o} !== {64'h8000_0004, 1'b0, 8'hFF, 64'h0}) begin
               errors++;
               $display("FAIL lock_iphase c=%0d actual=%h/%b/%h/%h required=80000004/0/ff/0", c, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o);
            end
         end else if (c == 4) begin
            checks++;
            if ({bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o} !== {64'h200, 1'b1, 8'h0F, 64'hDEAD_BEEF}) begin
               errors++;
               $display("FAIL lock_dphase actual=%h/%b/%h/%h required=200/1/0f/deadbeef", bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o);
            end
         end
         if (exp_i) sb_q.push_back({1'b0, 64'h1111_2222});
         if (exp_d) sb_q.push_back({1'b1, rd_pat(2, 6)});
      end
      end_test("lock");
   endtask

   task automatic test_lock_drop();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         imem_req_i = (c == 0); imem_addr_i = 64'h8000_0010;
         dmem_req_i = (c == 1 || c == 2); dmem_addr_i = 64'h400;
         bus_gnt_i = (c >= 1); bus_rvalid_i = (c == 3); bus_rdata_i = rd_pat(3, c);
         #1;
         checks++;
         if ({bus_req_o, imem_gnt_o, dmem_gnt_o} !== {(c == 0 || c == 2), 1'b0, (c == 2)}) begin
            errors++;
            $display("FAIL drop_gnt c=%0d actual=%b required=%b", c, {bus_req_o, imem_gnt_o, dmem_gnt_o}, {(c == 0 || c == 2), 1'b0, (c == 2)});
         end
         if (c == 2) sb_q.push_back({1'b1, rd_pat(3, 3)});
      end
      end_test("drop");
   endtask

   task automatic test_capacity();
      int   cnt_exp[10];
      int   resp[3];
      int   gi;
      logic exp_req;
      cnt_exp = '{0, 1, 2, 2, 2, 2, 1, 2, 1, 0};
      resp    = '{5, 7, 8};
      gi      = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         dmem_req_i = (c <= 6); dmem_addr_i = 64'h300; dmem_be_i = 8'hFF;
         bus_gnt_i = 1'b1; bus_rvalid_i = (c == 5 || c == 7 || c == 8); bus_rdata_i = rd_pat(4, c);
         #1;
         exp_req = (c < 2 || c == 6);
         checks++;
         if ({bus_req_o, dmem_gnt_o, imem_gnt_o} !== {exp_req, exp_req, 1'b0}) begin
            errors++;
            $display("FAIL cap_req c=%0d actual=%b required=%b", c, {bus_req_o, dmem_gnt_o, imem_gnt_o}, {exp_req, exp_req, 1'b0});
         end
         checks++;
         if (outst_cnt_o !== 3'(cnt_exp[c])) begin
            errors++;
            $display("FAIL cap_outst c=%0d actual=%0d required=%0d", c, outst_cnt_o, cnt_exp[c]);
         end
         if (exp_req && gi < 3) begin
            sb_q.push_back({1'b1, rd_pat(4, resp[gi])});
            gi++;
         end
      end
      end_test("cap");
   endtask

   task automatic test_halves();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         imem_req_i = (c < 2); imem_addr_i = (c == 0) ? 64'h8000_0004 : 64'h8000_0000;
         bus_gnt_i = 1'b1; bus_rvalid_i = (c == 1 || c == 2); bus_rdata_i = 64'h1111_2222_3333_4444;
         #1;
         checks++;
         if ({imem_gnt_o, outst_cnt_o} !== {(c < 2), ((c == 1 || c == 2) ? 3'd1 : 3'd0)}) begin
            errors++;
            $display("FAIL halves c=%0d actual=%b required=%b", c, {imem_gnt_o, outst_cnt_o}, {(c < 2), ((c == 1 || c == 2) ? 3'd1 : 3'd0)});
         end
         if (c == 0) sb_q.push_back({1'b0, 64'h1111_2222});
         if (c == 1) sb_q.push_back({1'b0, 64'h3333_4444});
      end
      end_test("halves");
   endtask

   task automatic test_spurious();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         bus_rvalid_i = (c == 0 || c == 2); bus_rdata_i = 64'h5555_6666_7777_8888;
         #1;
         checks++;
         if ({err_o, imem_rvalid_o, dmem_rvalid_o} !== {(c >= 1), 2'b00}) begin
            errors++;
            $display("FAIL spur c=%0d actual=%b required=%b", c, {err_o, imem_rvalid_o, dmem_rvalid_o}, {(c >= 1), 2'b00});
         end
      end
      do_reset();
      #1;
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL spur_clear actual=%b required=0", err_o);
      end
      // Grant and rvalid in the same cycle on an empty FIFO: the rvalid is spurious
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         dmem_req_i = (c == 0); dmem_addr_i = 64'h500;
         bus_gnt_i = 1'b1; bus_rvalid_i = (c <= 1); bus_rdata_i = rd_pat(5, c);
         #1;
         checks++;
         if ({dmem_gnt_o, dmem_rvalid_o, err_o, outst_cnt_o} !== {(c == 0), (c == 1), (c >= 1), ((c == 1) ? 3'd1 : 3'd0)}) begin
            errors++;
            $display("FAIL same_cycle c=%0d actual=%b required=%b", c, {dmem_gnt_o, dmem_rvalid_o, err_o, outst_cnt_o},
                     {(c == 0), (c == 1), (c >= 1), ((c == 1) ? 3'd1 : 3'd0)});
         end
         if (c == 0) sb_q.push_back({1'b1, rd_pat(5, 1)});
      end
      end_test("spur");
   endtask

   task automatic test_reset_midflight();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         dmem_req_i = (c < 2); dmem_addr_i = 64'h600; bus_gnt_i = 1'b1;
      end
      #1;
      checks++;
      if ({outst_cnt_o, bus_req_o} !== {3'd2, 1'b0}) begin
         errors++;
         $display("FAIL mid_full actual=%b required=%b", {outst_cnt_o, bus_req_o}, {3'd2, 1'b0});
      end
      do_reset();
      #1;
      checks++;
      if ({outst_cnt_o, err_o} !== 4'b0) begin
         errors++;
         $display("FAIL mid_reset actual=%b required=0000", {outst_cnt_o, err_o});
      end
      @(negedge clk_i);
      bus_rvalid_i = 1'b1; bus_rdata_i = 64'h9999_AAAA_BBBB_CCCC;
      #1;
      checks++;
      if ({imem_rvalid_o, dmem_rvalid_o, err_o} !== 3'b000) begin
         errors++;
         $display("FAIL mid_late_fwd actual=%b required=000", {imem_rvalid_o, dmem_rvalid_o, err_o});
      end
      @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      #1;
      checks++;
      if ({err_o, outst_cnt_o} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL mid_late_err actual=%b required=%b", {err_o, outst_cnt_o}, {1'b1, 3'd0});
      end
      end_test("mid");
   endtask

   initial begin
      rst_i = 1'b1;
      idle_in();
      test_reset();
      test_starvation();
      test_lock();
      test_lock_drop();
      test_capacity();
      test_halves();
      test_spurious();
      test_reset_midflight();
      @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
